// File: rtl/cla_sub_pipe_if.sv
// Operand/result bundle for the pipelined lookahead subtractor/adder.
// master = operand source + result consumer side, slave = the datapath.
interface cla_sub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_cout;
   logic             out_borrow;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_res, out_cout, out_borrow, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_res, out_cout, out_borrow, out_ovf, out_zero
   );
endinterface

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined A-B / A+B built from 4-bit carry-lookahead groups.
// Stage 1 holds per-bit propagate/generate and per-group P/G; stage 2 resolves
// the carries and registers the result with borrow/overflow/zero flags.
//
// Handshake: a beat moves across either interface on a rising edge where both
// valid and ready are high. The source may drop in_valid at any time (nothing
// is captured then); out_* holds steady while out_valid is high and out_ready
// is low. in_ready is combinational from out_ready so a full pipe can accept
// and deliver on the same edge without inserting a bubble.
module cla_sub_pipe #(
   parameter int WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   cla_sub_pipe_if.slave bus
);
   localparam int NG = WIDTH / 4;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
         $error("cla_sub_pipe: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   // stage 1 registers
   logic             s1_valid;
   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_g;
   logic [NG-1:0]    s1_gp;
   logic [NG-1:0]    s1_gg;
   logic             s1_cin;
   logic             s1_sub;
   logic             s1_a_msb;
   logic             s1_b_msb;

   // combinational front end
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic [NG-1:0]    gp_in;
   logic [NG-1:0]    gg_in;

   // carry resolution
   logic [NG:0]      gc;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_c;
   logic             cout_c;

   // pipeline control
   logic s2_en;
   logic s1_adv;
   logic in_fire;

   assign s2_en       = ~bus.out_valid | bus.out_ready;
   assign s1_adv      = s1_valid & s2_en;
   assign bus.in_ready = ~s1_valid | s2_en;
   assign in_fire     = bus.in_valid & bus.in_ready;

   // Subtraction is A + ~B + 1, so B is inverted and the carry-in is in_sub.
   assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
   assign p_in  = bus.in_a ^ b_eff;
   assign g_in  = bus.in_a & b_eff;

   // Group propagate/generate for each 4-bit slice.
   always_comb begin
      gp_in = '0;
      gg_in = '0;
      for (int k = 0; k < NG; k++) begin
         gp_in[k] = &p_in[4*k +: 4];
         gg_in[k] = g_in[4*k+3]
                  | (p_in[4*k+3] & g_in[4*k+2])
                  | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                  | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
      end
   end

   // Group carries chain across slices; inside each slice carries use lookahead.
   always_comb begin
      gc    = '0;
      carry = '0;
      gc[0] = s1_cin;
      for (int k = 0; k < NG; k++) begin
         gc[k+1]       = s1_gg[k] | (s1_gp[k] & gc[k]);
         carry[4*k]    = gc[k];
         carry[4*k+1]  = s1_g[4*k] | (s1_p[4*k] & gc[k]);
         carry[4*k+2]  = s1_g[4*k+1]
                       | (s1_p[4*k+1] & s1_g[4*k])
                       | (s1_p[4*k+1] & s1_p[4*k] & gc[k]);
         carry[4*k+3]  = s1_g[4*k+2]
                       | (s1_p[4*k+2] & s1_g[4*k+1])
                       | (s1_p[4*k+2] & s1_p[4*k+1] & s1_g[4*k])
                       | (s1_p[4*k+2] & s1_p[4*k+1] & s1_p[4*k] & gc[k]);
      end
      sum_c = s1_p ^ carry;
   end

   assign cout_c = gc[NG];

   // Stage 1: capture propagate/generate on an accepted input beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_g     <= '0;
         s1_gp    <= '0;
         s1_gg    <= '0;
         s1_cin   <= 1'b0;
         s1_sub   <= 1'b0;
         s1_a_msb <= 1'b0;
         s1_b_msb <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_p     <= p_in;
            s1_g     <= g_in;
            s1_gp    <= gp_in;
            s1_gg    <= gg_in;
            s1_cin   <= bus.in_sub;
            s1_sub   <= bus.in_sub;
            s1_a_msb <= bus.in_a[WIDTH-1];
            s1_b_msb <= b_eff[WIDTH-1];
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: register result and flags whenever the output slot is free.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_res    <= '0;
         bus.out_cout   <= 1'b0;
         bus.out_borrow <= 1'b0;
         bus.out_ovf    <= 1'b0;
         bus.out_zero   <= 1'b0;
      end else if (s2_en) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_res    <= sum_c;
            bus.out_cout   <= cout_c;
            bus.out_borrow <= s1_sub & ~cout_c;
            bus.out_ovf    <= (s1_a_msb == s1_b_msb) & (sum_c[WIDTH-1] != s1_a_msb);
            bus.out_zero   <= ~|sum_c;
         end
      end
   end
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: directed corner cases, random
// streaming, backpressure and reset-while-full against an arithmetic model.
module tb_cla_sub_pipe;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cla_sub_pipe_if #(.WIDTH(W)) bus ();

   cla_sub_pipe #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // expected entries packed as {cout, borrow, ovf, zero, res}
   logic [W+3:0] exp_q[$];
   int           lat_q[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           accepted = 0;
   bit           chk_lat = 1'b0;
   logic [W-1:0] corners[4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Plain integer arithmetic: unsigned for result/carry/borrow, signed for overflow.
   function automatic logic [W+3:0] model(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
      longint ua, ub, sa, sb, r, sr, smax, smin;
      logic [63:0] rv;
      bit cout, borrow, ovf, zero;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      if (sub) begin
         r      = ua - ub;
         sr     = sa - sb;
         cout   = (ua >= ub);
         borrow = (ua < ub);
      end else begin
         r      = ua + ub;
         sr     = sa + sb;
         cout   = (r >= (longint'(1) <<< W));
         borrow = 1'b0;
      end
      ovf  = (sr > smax) || (sr < smin);
      rv   = r;
      zero = (rv[W-1:0] == '0);
      return {cout, borrow, ovf, zero, rv[W-1:0]};
   endfunction

   // One clock: drive at the falling edge, then score what the next rising edge will transfer.
   task automatic step(input bit v, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ordy, input bit use_d, input logic [W+3:0] dexp);
      int lat;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_sub    = sub;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = ordy;
      #1;
      if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            check("out_res", bus.out_res, exp_q[0][W-1:0]);
            check("out_flags", {bus.out_cout, bus.out_borrow, bus.out_ovf, bus.out_zero},
                  exp_q[0][W+3:W]);
            if (bus.out_ready) begin
               void'(exp_q.pop_front());
               lat = lat_q.pop_front();
               if (chk_lat) check("latency", cyc - lat, 2);
            end
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         exp_q.push_back(use_d ? dexp : model(sub, a, b));
         lat_q.push_back(cyc);
         accepted++;
      end
      cyc++;
   endtask

   task automatic rand_op(input bit v, input bit ordy);
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      step(v, 1'($urandom_range(0, 1)), a, b, ordy, 1'b0, '0);
   endtask

   task automatic dir(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input bit cout, input bit borrow,
                      input bit ovf, input bit zero);
      step(1'b1, sub, a, b, 1'b1, 1'b1, {cout, borrow, ovf, zero, res});
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic check_reset_state();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_res", bus.out_res, 0);
      check("rst_out_flags", {bus.out_cout, bus.out_borrow, bus.out_ovf, bus.out_zero}, 0);
      check("rst_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      corners[0] = '0;
      corners[1] = '1;
      corners[2] = {1'b1, {(W-1){1'b0}}};
      corners[3] = {1'b0, {(W-1){1'b1}}};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sub    = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_state();

      // directed corner cases with hand-derived expectations
      chk_lat = 1'b1;
      dir(1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
      dir(1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
      dir(1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
      dir(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
      dir(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
      dir(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
      drain();

      // back-to-back streaming
      for (int i = 0; i < 100; i++) begin
         rand_op(1'b1, 1'b1);
         check("in_ready_stream", bus.in_ready, 1);
      end
      drain();

      // backpressure: exactly two beats fit, then in_ready drops
      chk_lat  = 1'b0;
      accepted = 0;
      for (int i = 0; i < 4; i++) begin
         rand_op(1'b1, 1'b0);
         if (i >= 2) check("in_ready_full", bus.in_ready, 0);
      end
      check("bp_accepted", accepted, 2);
      for (int i = 0; i < 20; i++) rand_op(1'b1, 1'b1);
      drain();

      // random valid/ready mix
      for (int i = 0; i < 80; i++) rand_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();

      // reset with both stages full
      for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b0);
      check("full_before_rst", bus.in_ready, 0);
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      exp_q.delete();
      lat_q.delete();
      check_reset_state();
      chk_lat = 1'b1;
      step(1'b1, 1'b1, 16'h0010, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 1'b0, 16'h000F});
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cla_sub_pipe.md
Name: cla_sub_pipe

Overview:
- Pipelined WIDTH-bit subtractor/adder (A-B or A+B) built from 4-bit carry-lookahead groups.
- The datapath counterpart to the team's lookahead adder: it produces the difference, borrow and comparison flags that the adder alone does not supply.
- Sits between an operand source and a consumer, with valid/ready handshakes on both sides.
- Two register stages; throughput 1 op/cycle, latency 2 cycles when not stalled.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 (elaboration error otherwise).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  minuend / addend A
in_b  input  WIDTH  subtrahend / addend B
in_sub  input  1  1 = A-B, 0 = A+B
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
out_res  output  WIDTH  result, mod 2^WIDTH
out_cout  output  1  raw carry out of MSB (sub: 1 = no borrow)
out_borrow  output  1  sub: ~cout (A<B unsigned); add: 0
out_ovf  output  1  signed two's-complement overflow
out_zero  output  1  out_res == 0

Behaviour:
- Operation: B' = in_sub ? ~in_b : in_b; cin = in_sub. All arithmetic uses A + B' + cin.
- Stage 1, registered on input handshake (in_valid & in_ready):
  - per-bit p = A^B', g = A&B';
  - per-group (4-bit) P = &p, G = lookahead generate;
  - also register cin, in_sub, A[MSB], B'[MSB].
- Stage 2, registered when stage 1 advances:
  - group carries c[k+1] = G[k] | P[k]&c[k], c[0] = cin;
  - in-group carries by 4-bit lookahead equations;
  - sum = p ^ carries; cout = carry out of last group;
  - ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]);
  - borrow = in_sub & ~cout;
  - zero = ~|sum.
- Pipeline control: s2_en = ~out_valid | out_ready; s1_adv = s1_valid & s2_en; in_ready = ~s1_valid | s2_en (combinational from out_ready allowed).
- Handshakes:
  - Beat transfers on valid&ready at the clock edge.
  - Output fields stay stable while out_valid & ~out_ready.
  - in_valid may drop without handshake; nothing is captured then.
- Simultaneous accept/deliver: when out_ready=1 and stage 1 is full, stage 2 loads the new beat in the same edge it delivers the old one; no bubble inserted.
- Full: both stages valid and out_ready=0 -> in_ready=0. At most 2 beats in flight. Order preserved; no beat dropped or duplicated.
- Empty: out_valid=0; out_* data holds last value (don't-care to consumer).
- Reset (any cycle, including mid-stall):
  - s1_valid=0, out_valid=0, out_res=0, out_cout=0, out_borrow=0, out_ovf=0, out_zero=0;
  - in_ready=1 in the first cycle after reset;
  - in-flight beats discarded.
- Wrap-around: results are modulo 2^WIDTH; no saturation.

Test Plan:
- Sub, WIDTH=16, out_ready=1: A=0x0005, B=0x0003 -> 2 cycles later out_res=0x0002, cout=1, borrow=0, ovf=0, zero=0.
- Sub 0x0003-0x0005 -> out_res=0xFFFE, borrow=1, ovf=0; sub 0x7FFF-0xFFFF -> out_res=0x8000, ovf=1, borrow=1; sub 0x1234-0x1234 -> out_res=0x0000, zero=1, cout=1.
- Add 0xFFFF+0x0001 -> out_res=0x0000, cout=1, borrow=0, zero=1; add 0x7FFF+0x0001 -> out_res=0x8000, ovf=1, cout=0.
- Back-to-back streaming of 100 random ops with out_ready=1 -> one result per cycle after 2-cycle latency, all matching a reference model, in_ready constantly 1.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 beats accepted, in_ready=0 thereafter, out_* stable; release out_ready -> the 2 results in order, then streaming resumes with no loss.
- Assert rst for 1 cycle with both stages full -> next cycle out_valid=0, all out_* = 0, in_ready=1; next op completes normally.
